// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, function codes and shifter modes.
// Imported by the execute-stage ALU and by the decode stage.
package alu_pkg;

   localparam int ALU_W = 32;

   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SLL  = 5'd1;
   localparam logic [4:0] ALU_XOR  = 5'd2;
   localparam logic [4:0] ALU_SRL  = 5'd3;
   localparam logic [4:0] ALU_OR   = 5'd4;
   localparam logic [4:0] ALU_AND  = 5'd5;
   localparam logic [4:0] ALU_SUB  = 5'd6;
   localparam logic [4:0] ALU_SRA  = 5'd7;
   localparam logic [4:0] ALU_SLT  = 5'd8;
   localparam logic [4:0] ALU_SLTU = 5'd9;

   typedef enum logic [1:0] {
      SH_SLL = 2'd0,
      SH_SRL = 2'd1,
      SH_SRA = 2'd2
   } shift_mode_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational 32-bit barrel shifter (SLL/SRL/SRA); latency 0, no backpressure.
// Built as five log2 stages; fill bit is 0 except for SRA, which replicates data[31].
module alu_shifter
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] i_data,
   input  logic [4:0]       i_shamt,
   input  shift_mode_t      i_mode,
   output logic [ALU_W-1:0] o_result
);

   logic [ALU_W-1:0] w_in;
   logic [ALU_W-1:0] w_stage [0:5];
   logic             w_fill;

   // Left shifts are done as right shifts of the bit-reversed word.
   always_comb begin
      w_fill = (i_mode == SH_SRA) ? i_data[ALU_W-1] : 1'b0;
      for (int i = 0; i < ALU_W; i++) begin
         w_in[i] = (i_mode == SH_SLL) ? i_data[ALU_W-1-i] : i_data[i];
      end
   end

   assign w_stage[0] = w_in;

   genvar g;
   generate
      for (g = 0; g < 5; g++) begin : g_stage
         localparam int SH = 1 << g;
         assign w_stage[g+1] = i_shamt[g] ? {{SH{w_fill}}, w_stage[g][ALU_W-1:SH]}
                                          : w_stage[g];
      end
   endgenerate

   always_comb begin
      for (int i = 0; i < ALU_W; i++) begin
         o_result[i] = (i_mode == SH_SLL) ? w_stage[5][ALU_W-1-i] : w_stage[5][i];
      end
   end

endmodule

// File: rtl/alu.sv
// Execute-stage 32-bit integer ALU; latency 1 cycle (registered result).
// No handshake or stall: a new operation is accepted every clock.
module alu
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [ALU_W-1:0] io_input1,
   input  logic [ALU_W-1:0] io_input2,
   input  logic [4:0]       io_function,
   output logic [ALU_W-1:0] io_output
);

   logic [ALU_W-1:0] r_result;
   logic [ALU_W-1:0] w_next;
   logic [ALU_W-1:0] w_shift;
   shift_mode_t      w_mode;
   logic             w_slt;
   logic             w_sltu;

   always_comb begin
      case (io_function)
         ALU_SLL: w_mode = SH_SLL;
         ALU_SRL: w_mode = SH_SRL;
         default: w_mode = SH_SRA;
      endcase
   end

   alu_shifter u_shifter (
      .i_data   (io_input1),
      .i_shamt  (io_input2[4:0]),
      .i_mode   (w_mode),
      .o_result (w_shift)
   );

   assign w_slt  = $signed(io_input1) < $signed(io_input2);
   assign w_sltu = io_input1 < io_input2;

   always_comb begin
      case (io_function)
         ALU_ADD:  w_next = io_input1 + io_input2;
         ALU_SUB:  w_next = io_input1 - io_input2;
         ALU_XOR:  w_next = io_input1 ^ io_input2;
         ALU_OR:   w_next = io_input1 | io_input2;
         ALU_AND:  w_next = io_input1 & io_input2;
         ALU_SLL,
         ALU_SRL,
         ALU_SRA:  w_next = w_shift;
         ALU_SLT:  w_next = {{(ALU_W-1){1'b0}}, w_slt};
         ALU_SLTU: w_next = {{(ALU_W-1){1'b0}}, w_sltu};
         default:  w_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_result <= '0;
      end else begin
         r_result <= w_next;
      end
   end

   assign io_output = r_result;

endmodule

// File: tb/tb_alu.sv
// Directed and randomized checks of alu against an arithmetic reference model.
module tb_alu;

   logic        clk;
   logic        rst;
   logic [31:0] io_input1;
   logic [31:0] io_input2;
   logic [4:0]  io_function;
   logic [31:0] io_output;

   int total;
   int bad;

   alu dut (
      .clk         (clk),
      .rst         (rst),
      .io_input1   (io_input1),
      .io_input2   (io_input2),
      .io_function (io_function),
      .io_output   (io_output)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference written with plain integer arithmetic: shifts as multiply/divide by 2^n.
   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] fn);
      longint ua, ub, sa, sb, p2, q;
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      sa = a[31] ? ua - 64'sd4294967296 : ua;
      sb = b[31] ? ub - 64'sd4294967296 : ub;
      p2 = 64'sd1;
      for (int i = 0; i < int'(b[4:0]); i++) p2 = p2 * 2;
      case (fn)
         5'd0: return 32'(ua + ub);
         5'd1: return 32'(ua * p2);
         5'd2: return a ^ b;
         5'd3: return 32'(ua / p2);
         5'd4: return a | b;
         5'd5: return a & b;
         5'd6: return 32'(ua + 64'sd4294967296 - ub);
         5'd7: begin
            if (sa >= 0) q = sa / p2;
            else         q = -((-sa + p2 - 1) / p2);
            return 32'(q);
         end
         5'd8: return (sa < sb) ? 32'd1 : 32'd0;
         5'd9: return (ua < ub) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] exp);
      total++;
      assert (io_output === exp) else begin
         bad++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, io_output, exp);
      end
   endtask

   // Drive one operation, let one rising edge capture it, then compare.
   task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] fn, input logic [31:0] exp);
      io_input1   = a;
      io_input2   = b;
      io_function = fn;
      @(posedge clk);
      #1;
      check(tag, exp);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [4:0]  rf;
      total = 0;
      bad   = 0;

      rst         = 1'b1;
      io_input1   = 32'h1242512F;
      io_input2   = 32'hFA34512F;
      io_function = 5'd0;
      #2 rst = 1'b0;
      #1 check("reset_before_edge", 32'h0);
      repeat (2) begin
         @(posedge clk);
         #1 check("reset_held", 32'h0);
      end
      #3 rst = 1'b1;
      issue("first_after_reset", 32'h1242512F, 32'hFA34512F, 5'd0, 32'h0C76A25E);

      issue("add",   32'h12345678, 32'h09ABCDEF, 5'd0, 32'h1BE02467);
      issue("sub",   32'h12345678, 32'h9ABCDEF0, 5'd6, 32'h77777788);
      issue("xor",   32'h12345678, 32'h9ABCDEF0, 5'd2, 32'h88888888);
      issue("or",    32'h12345678, 32'h9ABCDEF0, 5'd4, 32'h9ABCDEF8);
      issue("and",   32'h12345678, 32'h9ABCDEF0, 5'd5, 32'h12345670);
      issue("sll4",  32'h12345678, 32'h00000004, 5'd1, 32'h23456780);
      issue("srl4",  32'h12345678, 32'h00000004, 5'd3, 32'h01234567);
      issue("sra4",  32'h12345678, 32'h00000004, 5'd7, 32'h01234567);
      issue("sra_neg", 32'h80000000, 32'h00000004, 5'd7, 32'hF8000000);
      issue("sll_hi_b", 32'h12345678, 32'hFFFFFFE4, 5'd1, 32'h23456780);
      issue("srl_by0", 32'h87654321, 32'hFFFFFFE0, 5'd3, 32'h87654321);
      issue("srl31", 32'h80000000, 32'h0000001F, 5'd3, 32'h00000001);
      issue("sra31", 32'h80000000, 32'h0000001F, 5'd7, 32'hFFFFFFFF);
      issue("slt",   32'h80000000, 32'h7FFFFFFF, 5'd8, 32'h00000001);
      issue("sltu",  32'h80000000, 32'h7FFFFFFF, 5'd9, 32'h00000000);
      issue("slt_eq",  32'hDEADBEEF, 32'hDEADBEEF, 5'd8, 32'h0);
      issue("sltu_eq", 32'hDEADBEEF, 32'hDEADBEEF, 5'd9, 32'h0);
      issue("illegal10", 32'hFFFFFFFF, 32'h12345678, 5'd10, 32'h0);
      issue("illegal31", 32'hFFFFFFFF, 32'h12345678, 5'd31, 32'h0);

      // Inputs wiggling between edges must not disturb the registered output.
      io_input1 = 32'h0F0F0F0F;
      io_function = 5'd4;
      #2 check("hold_between_edges", 32'h0);

      // Mid-stream reset: clear is immediate, then held across an edge.
      issue("pre_reset_op", 32'h00000005, 32'h00000003, 5'd0, 32'h00000008);
      #2 rst = 1'b0;
      #1 check("async_midstream_reset", 32'h0);
      @(posedge clk);
      #1 check("midstream_reset_held", 32'h0);
      rst = 1'b1;

      // Back-to-back randomized operations, one per cycle.
      for (int i = 0; i < 300; i++) begin
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
         if ($urandom_range(0, 3) == 0) rb = {$urandom_range(0, 1) ? 27'h7FFFFFF : 27'h0, rb[4:0]};
         rf = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 9));
         issue($sformatf("rand%0d_fn%0d", i, rf), ra, rb, rf, ref_alu(ra, rb, rf));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
